jogo_sequencia_param: RTL and testbench
=======================================

Name: jogo_sequencia_param

Overview:
- Parametrised successor of the memory-game circuit. Holds a writable sequence of DEPTH words of N bits each.
- After `iniciar`, the player enters one word per `jogar` press. Each word is compared in order against the stored sequence, ending in a hit (acertou) or miss (errou).
- Adds over the previous generation: a run-time loadable sequence, edge-detected play input, parametrised width and depth, and an optional timeout.
- Outputs raw debug buses; the top level instantiates hexa7seg decoders.

Parameters:
- N, 4: width of `chaves` and of each memory word.
- DEPTH, 16: sequence length; must be >= 2. AW = $clog2(DEPTH).
- TIMEOUT_CYCLES, 1000: cycles allowed in ESPERA (used only with TIMEOUT_EN).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  start/restart request, level-sampled.
- jogar  in  1  play strobe; rising edge detected internally.
- chaves  in  N  player word.
- mem_we  in  1  sequence write enable.
- mem_addr  in  AW  write address.
- mem_wdata  in  N  write data.
- pronto  out  1  high in ACERTOU/ERROU/TIMEOUT.
- acertou  out  1  high in ACERTOU.
- errou  out  1  high in ERROU or TIMEOUT.
- db_estado  out  4  state code.
- db_contagem  out  AW  current address.
- db_memoria  out  N  mem[db_contagem], combinational read.
- db_chaves  out  N  registered player word.
- db_igual  out  1  db_chaves == db_memoria.
- db_timeout  out  1  high in TIMEOUT (0 when feature is off).

Behaviour:
- Reset: state=IDLE, contagem=0, db_chaves=0, jogar_d=0, timeout counter=0. All outputs 0 except the combinational db_memoria/db_igual. Memory contents are NOT reset.
- Edge detect: jogar_d <= jogar every cycle; edge = jogar & ~jogar_d. A held `jogar` counts once.
- States (db_estado): IDLE 0x0, PREPARA 0x1, ESPERA 0x2, COMPARA 0x4, PROXIMO 0x5, ACERTOU 0xA, TIMEOUT 0xD, ERROU 0xE.
- IDLE: iniciar=1 -> PREPARA.
- PREPARA: contagem<=0, db_chaves<=0 -> ESPERA.
- ESPERA: on edge, db_chaves<=chaves sampled that cycle -> COMPARA. Otherwise stay.
- COMPARA:
  - !igual -> ERROU.
  - igual and contagem==DEPTH-1 -> ACERTOU.
  - else -> PROXIMO.
- PROXIMO: contagem<=contagem+1 -> ESPERA.
- ACERTOU/ERROU/TIMEOUT: hold outputs. iniciar=1 -> PREPARA (direct restart, no IDLE pass).
- Latency: edge detected in cycle E -> acertou/errou high in cycle E+2. Inter-word turnaround is 3 cycles.
- Counter never wraps in play; the last address leads to ACERTOU.
- Memory write:
  - Accepted only in IDLE, ACERTOU, ERROU, TIMEOUT: mem[mem_addr]<=mem_wdata.
  - Ignored in PREPARA/ESPERA/COMPARA/PROXIMO.
  - A write and iniciar in the same cycle: the write completes, then the state moves.
- Simultaneous edge with iniciar in ESPERA: iniciar ignored, edge processed.
- Reset mid-game: next cycle IDLE, outputs 0, memory intact.
- mem_addr >= DEPTH (non-power-of-2 DEPTH): write ignored.

Optional Feature:
- TIMEOUT_EN defined:
  - A counter clears on entry to ESPERA and increments each ESPERA cycle without an edge.
  - Reaching TIMEOUT_CYCLES-1 with no edge -> TIMEOUT.
  - In TIMEOUT: errou=1, pronto=1, db_timeout=1.
  - An edge in the same cycle as expiry wins (-> COMPARA).
- TIMEOUT_EN undefined: no counter, TIMEOUT unreachable, db_timeout tied to 0, ESPERA waits forever.

Test Plan:
- Bench setup: DEPTH=4, N=4 throughout.
- Full hit: write 3,7,A,1 in IDLE, iniciar, play 3,7,A,1 -> acertou=1, pronto=1, errou=0, db_estado=0xA, db_contagem=3; acertou rises exactly 2 cycles after the 4th edge.
- Miss at word 2: same memory, play 3,5 -> errou=1, db_estado=0xE, db_contagem=1, db_chaves=5, db_igual=0.
- Held jogar: hold jogar high 10 cycles with chaves=3 -> only contagem 0->1, state returns to ESPERA(0x2). Release and press with 7 -> contagem=2.
- Write lockout plus restart: mem_we during ESPERA with addr0=F -> ignored, game still hits with 3. Then from ACERTOU write addr0=F plus iniciar, play F,7,A,1 -> acertou.
- Reset mid-game: reset asserted at contagem=2 -> next cycle db_estado=0, all outputs 0; replay 3,7,A,1 -> acertou (memory retained).
- With TIMEOUT_EN and TIMEOUT_CYCLES=8: iniciar, no jogar -> db_estado=0xD, errou=1, db_timeout=1 after 8 ESPERA cycles. An edge on the 8th cycle -> COMPARA instead.

Source files
------------

// File: rtl/jogo_sequencia_param.sv
// Memory game: the player replays a run-time loadable sequence of DEPTH words of N bits, one word per jogar press.
// Latency: a jogar edge in cycle E shows acertou/errou in cycle E+2; consecutive words are 3 cycles apart.
// No backpressure: jogar is edge-detected, and sequence writes are dropped while a game is running.
// Optional feature: define TIMEOUT_EN to abort a game after TIMEOUT_CYCLES idle cycles in ESPERA.
module jogo_sequencia_param #(
  parameter int N              = 4,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic                     jogar,
  input  logic [N-1:0]             chaves,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_addr,
  input  logic [N-1:0]             mem_wdata,
  output logic                     pronto,
  output logic                     acertou,
  output logic                     errou,
  output logic [3:0]               db_estado,
  output logic [$clog2(DEPTH)-1:0] db_contagem,
  output logic [N-1:0]             db_memoria,
  output logic [N-1:0]             db_chaves,
  output logic                     db_igual,
  output logic                     db_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Reject configurations the game cannot play: a one-word sequence or an empty timeout window.
  if (DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("jogo_sequencia_param: DEPTH must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  // State codes double as the db_estado debug value.
  typedef enum logic [3:0] {
    S_IDLE    = 4'h0,
    S_PREPARA = 4'h1,
    S_ESPERA  = 4'h2,
    S_COMPARA = 4'h4,
    S_PROXIMO = 4'h5,
    S_ACERTOU = 4'hA,
    S_TIMEOUT = 4'hD,
    S_ERROU   = 4'hE
  } estado_t;

  estado_t       r_estado;
  estado_t       w_prox;
  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_cont;
  logic [N-1:0]  r_chaves;
  logic          r_jogar_d;
  logic          w_borda;
  logic          w_igual;
  logic          w_mem_livre;
  logic          w_tmo_fim;

  assign w_borda     = jogar & ~r_jogar_d;
  assign db_memoria  = r_mem[r_cont];
  assign w_igual     = (r_chaves == db_memoria);
  assign db_igual    = w_igual;
  assign db_contagem = r_cont;
  assign db_chaves   = r_chaves;
  assign db_estado   = r_estado;

  // The sequence may only change while no game is in progress.
  assign w_mem_livre = (r_estado == S_IDLE)    || (r_estado == S_ACERTOU) ||
                       (r_estado == S_ERROU)   || (r_estado == S_TIMEOUT);

`ifdef TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tmo;

  // Count idle ESPERA cycles; held at zero elsewhere so every entry to ESPERA starts a fresh window.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (r_estado == S_ESPERA && !w_borda) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  // An edge arriving in the expiry cycle still wins.
  assign w_tmo_fim = (r_tmo == TMO_LAST) && !w_borda;
`else
  assign w_tmo_fim = 1'b0;
`endif

  // Sequence storage: no reset, so a loaded sequence survives a mid-game reset; out-of-range addresses are dropped.
  always_ff @(posedge clock) begin
    if (!reset && mem_we && w_mem_livre && (32'(mem_addr) < DEPTH)) begin
      r_mem[mem_addr] <= mem_wdata;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= S_IDLE;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Datapath: play-edge history, word address and the captured player word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_jogar_d <= 1'b0;
      r_cont    <= '0;
      r_chaves  <= '0;
    end else begin
      r_jogar_d <= jogar;
      case (r_estado)
        S_PREPARA: begin
          r_cont   <= '0;
          r_chaves <= '0;
        end
        S_ESPERA: begin
          if (w_borda) begin
            r_chaves <= chaves;
          end
        end
        S_PROXIMO: r_cont <= r_cont + 1'b1;
        default:   ;
      endcase
    end
  end

  // Next-state and status outputs; iniciar is ignored while a word is pending.
  always_comb begin
    w_prox     = r_estado;
    pronto     = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    db_timeout = 1'b0;
    case (r_estado)
      S_IDLE: begin
        if (iniciar) w_prox = S_PREPARA;
      end
      S_PREPARA: w_prox = S_ESPERA;
      S_ESPERA: begin
        if (w_borda)        w_prox = S_COMPARA;
        else if (w_tmo_fim) w_prox = S_TIMEOUT;
      end
      S_COMPARA: begin
        if (!w_igual)                 w_prox = S_ERROU;
        else if (r_cont == LAST_ADDR) w_prox = S_ACERTOU;
        else                          w_prox = S_PROXIMO;
      end
      S_PROXIMO: w_prox = S_ESPERA;
      S_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        if (iniciar) w_prox = S_PREPARA;
      end
      S_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
        if (iniciar) w_prox = S_PREPARA;
      end
      S_TIMEOUT: begin
        pronto = 1'b1;
        errou  = 1'b1;
`ifdef TIMEOUT_EN
        db_timeout = 1'b1;
`endif
        if (iniciar) w_prox = S_PREPARA;
      end
      default: w_prox = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Bench for jogo_sequencia_param with DEPTH=4, N=4, TIMEOUT_CYCLES=8.
// Cycle table for a full game, directed corner sequences, then randomized games against a word-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_jogo_sequencia_param;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
`ifdef TIMEOUT_EN
  localparam int HOLD  = 8;
`else
  localparam int HOLD  = 10;
`endif

  logic       clock, reset, iniciar, jogar, mem_we;
  logic [3:0] chaves, mem_wdata;
  logic [1:0] mem_addr;
  logic       pronto, acertou, errou, db_igual, db_timeout;
  logic [3:0] db_estado, db_memoria, db_chaves;
  logic [1:0] db_contagem;

  int n_cmp = 0;
  int n_bad = 0;

  jogo_sequencia_param #(.N(N), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogar(jogar), .chaves(chaves),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pronto(pronto), .acertou(acertou), .errou(errou), .db_estado(db_estado),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_chaves(db_chaves),
    .db_igual(db_igual), .db_timeout(db_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       ini, jog, we;
    logic [3:0] chv, wd;
    logic [1:0] addr;
    logic [3:0] e_est, e_chv;
    logic [1:0] e_cnt;
    logic       e_pr, e_ac, e_er;
  } vec_t;

  vec_t tbl[18];
  logic [3:0] model_mem [DEPTH];

  function automatic vec_t mk(input logic ini, jog, input logic [3:0] chv, input logic we,
                              input logic [1:0] addr, input logic [3:0] wd, input logic [3:0] est,
                              input logic [1:0] cnt, input logic [3:0] echv, input logic pr, ac, er);
    vec_t v;
    v.ini = ini; v.jog = jog; v.chv = chv; v.we = we; v.addr = addr; v.wd = wd;
    v.e_est = est; v.e_cnt = cnt; v.e_chv = echv; v.e_pr = pr; v.e_ac = ac; v.e_er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_st(input string name, input logic [3:0] est, input logic [1:0] cnt,
                        input logic pr, input logic ac, input logic er);
    chk({name, ".estado"}, 32'(db_estado), 32'(est));
    chk({name, ".contagem"}, 32'(db_contagem), 32'(cnt));
    chk({name, ".pronto"}, 32'(pronto), 32'(pr));
    chk({name, ".acertou"}, 32'(acertou), 32'(ac));
    chk({name, ".errou"}, 32'(errou), 32'(er));
  endtask

  // One-cycle press; leaves the bench at the COMPARA outcome (PROXIMO, ACERTOU or ERROU).
  task automatic press(input logic [3:0] w);
    jogar = 1'b1; chaves = w;
    tick();
    jogar = 1'b0;
    tick();
  endtask

  // From a terminal state or IDLE, restart and land in ESPERA.
  task automatic start();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
  endtask

  task automatic play4(input string name, input logic [3:0] a, b, c, d);
    logic [3:0] w [4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    for (int i = 0; i < 4; i++) begin
      press(w[i]);
      if (i < 3) begin
        chk({name, ".step"}, 32'(db_estado), 32'h5);
        tick();
      end
    end
    chk_st({name, ".end"}, 4'hA, 2'd3, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    logic [3:0] w;
    int         gap;
    bit         done;

    reset = 1'b1; iniciar = 1'b0; jogar = 1'b0; chaves = '0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    chk_st("reset", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.chaves", 32'(db_chaves), 32'h0);
    chk("reset.timeout", 32'(db_timeout), 32'h0);

    // Full game, cycle by cycle: load 3,7,A,1 in IDLE then replay it.
    tbl[0]  = mk(0, 0, 4'h0, 1, 2'd0, 4'h3, 4'h0, 2'd0, 4'h0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 4'h0, 1, 2'd1, 4'h7, 4'h0, 2'd0, 4'h0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 4'h0, 1, 2'd2, 4'hA, 4'h0, 2'd0, 4'h0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 4'h0, 1, 2'd3, 4'h1, 4'h0, 2'd0, 4'h0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 4'h0, 0, 2'd0, 4'h0, 4'h1, 2'd0, 4'h0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h2, 2'd0, 4'h0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 4'h3, 0, 2'd0, 4'h0, 4'h4, 2'd0, 4'h3, 0, 0, 0);
    tbl[7]  = mk(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h5, 2'd0, 4'h3, 0, 0, 0);
    tbl[8]  = mk(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h2, 2'd1, 4'h3, 0, 0, 0);
    tbl[9]  = mk(0, 1, 4'h7, 0, 2'd0, 4'h0, 4'h4, 2'd1, 4'h7, 0, 0, 0);
    tbl[10] = mk(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h5, 2'd1, 4'h7, 0, 0, 0);
    tbl[11] = mk(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h2, 2'd2, 4'h7, 0, 0, 0);
    tbl[12] = mk(0, 1, 4'hA, 0, 2'd0, 4'h0, 4'h4, 2'd2, 4'hA, 0, 0, 0);
    tbl[13] = mk(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h5, 2'd2, 4'hA, 0, 0, 0);
    tbl[14] = mk(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h2, 2'd3, 4'hA, 0, 0, 0);
    tbl[15] = mk(0, 1, 4'h1, 0, 2'd0, 4'h0, 4'h4, 2'd3, 4'h1, 0, 0, 0);
    tbl[16] = mk(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'hA, 2'd3, 4'h1, 1, 1, 0);
    tbl[17] = mk(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'hA, 2'd3, 4'h1, 1, 1, 0);
    for (int r = 0; r < 18; r++) begin
      iniciar = tbl[r].ini; jogar = tbl[r].jog; chaves = tbl[r].chv;
      mem_we = tbl[r].we; mem_addr = tbl[r].addr; mem_wdata = tbl[r].wd;
      tick();
      chk_st($sformatf("tbl%0d", r), tbl[r].e_est, tbl[r].e_cnt, tbl[r].e_pr, tbl[r].e_ac, tbl[r].e_er);
      chk($sformatf("tbl%0d.chaves", r), 32'(db_chaves), 32'(tbl[r].e_chv));
    end
    jogar = 1'b0; mem_we = 1'b0;
    chk("hit.igual", 32'(db_igual), 32'h1);
    chk("hit.memoria", 32'(db_memoria), 32'h1);

    // Miss on the second word.
    start();
    press(4'h3);
    chk("miss.step", 32'(db_estado), 32'h5);
    tick();
    press(4'h5);
    chk_st("miss", 4'hE, 2'd1, 1'b1, 1'b0, 1'b1);
    chk("miss.chaves", 32'(db_chaves), 32'h5);
    chk("miss.igual", 32'(db_igual), 32'h0);
    tick();
    chk("miss.hold", 32'(db_estado), 32'hE);

    // Held jogar counts once.
    start();
    jogar = 1'b1; chaves = 4'h3;
    repeat (HOLD) tick();
    chk_st("held", 4'h2, 2'd1, 1'b0, 1'b0, 1'b0);
    jogar = 1'b0;
    tick();
    chk_st("held.rel", 4'h2, 2'd1, 1'b0, 1'b0, 1'b0);
    press(4'h7);
    chk("held.p7", 32'(db_estado), 32'h5);
    tick();
    chk_st("held.cnt2", 4'h2, 2'd2, 1'b0, 1'b0, 1'b0);

    // Write during ESPERA is dropped; the game still finishes on the old sequence.
    mem_we = 1'b1; mem_addr = 2'd0; mem_wdata = 4'hF;
    tick();
    mem_we = 1'b0;
    chk("lock.estado", 32'(db_estado), 32'h2);
    press(4'hA);
    tick();
    press(4'h1);
    chk_st("lock.hit", 4'hA, 2'd3, 1'b1, 1'b1, 1'b0);
    start();
    chk("lock.mem0", 32'(db_memoria), 32'h3);
    play4("lock.replay", 4'h3, 4'h7, 4'hA, 4'h1);

    // Write plus iniciar in the same cycle: write lands, state moves to PREPARA.
    mem_we = 1'b1; mem_addr = 2'd0; mem_wdata = 4'hF; iniciar = 1'b1;
    tick();
    chk("wrst.prepara", 32'(db_estado), 32'h1);
    mem_we = 1'b0; iniciar = 1'b0;
    tick();
    chk("wrst.mem0", 32'(db_memoria), 32'hF);
    play4("wrst.play", 4'hF, 4'h7, 4'hA, 4'h1);
    mem_we = 1'b1; mem_addr = 2'd0; mem_wdata = 4'h3;
    tick();
    mem_we = 1'b0;

    // Reset in the middle of a game keeps the memory.
    start();
    press(4'h3); tick();
    press(4'h7); tick();
    chk_st("rst.pre", 4'h2, 2'd2, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_st("rst.post", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.chaves", 32'(db_chaves), 32'h0);
    chk("rst.timeout", 32'(db_timeout), 32'h0);
    start();
    play4("rst.replay", 4'h3, 4'h7, 4'hA, 4'h1);

`ifdef TIMEOUT_EN
    // Eight silent ESPERA cycles expire; an edge in the eighth cycle wins.
    start();
    repeat (TMO - 1) tick();
    chk("tmo.before", 32'(db_estado), 32'h2);
    tick();
    chk_st("tmo", 4'hD, 2'd0, 1'b1, 1'b0, 1'b1);
    chk("tmo.flag", 32'(db_timeout), 32'h1);
    start();
    repeat (TMO - 1) tick();
    jogar = 1'b1; chaves = 4'h3;
    tick();
    jogar = 1'b0;
    chk("tmo.edge", 32'(db_estado), 32'h4);
    chk("tmo.edgeflag", 32'(db_timeout), 32'h0);
    tick();
    chk("tmo.prox", 32'(db_estado), 32'h5);
    tick();
`else
    // Without the timeout feature ESPERA waits indefinitely.
    start();
    repeat (3 * TMO) tick();
    chk("notmo.wait", 32'(db_estado), 32'h2);
    chk("notmo.flag", 32'(db_timeout), 32'h0);
    press(4'h3);
    tick();
`endif
    chk_st("finish.cnt1", 4'h2, 2'd1, 1'b0, 1'b0, 1'b0);
    press(4'h7); tick();
    press(4'hA); tick();
    press(4'h1);
    chk_st("finish", 4'hA, 2'd3, 1'b1, 1'b1, 1'b0);

    // Randomized games: model is the stored word list plus the word index of the game.
    for (int g = 0; g < 40; g++) begin
      for (int a = 0; a < DEPTH; a++) begin
        model_mem[a] = 4'($urandom_range(0, 15));
        mem_we = 1'b1; mem_addr = 2'(a); mem_wdata = model_mem[a];
        tick();
      end
      mem_we = 1'b0;
      start();
      chk("rnd.start", 32'(db_estado), 32'h2);
      done = 1'b0;
      for (int i = 0; i < DEPTH && !done; i++) begin
        gap = int'($urandom_range(0, 3));
        repeat (gap) begin
          mem_we = 1'($urandom_range(0, 1));
          mem_addr = 2'($urandom_range(0, 3));
          mem_wdata = 4'($urandom_range(0, 15));
          tick();
        end
        mem_we = 1'b0;
        chk($sformatf("rnd%0d.mem%0d", g, i), 32'(db_memoria), 32'(model_mem[i]));
        w = ($urandom_range(0, 3) != 0) ? model_mem[i] : 4'($urandom_range(0, 15));
        press(w);
        if (w != model_mem[i]) begin
          chk_st($sformatf("rnd%0d.miss", g), 4'hE, 2'(i), 1'b1, 1'b0, 1'b1);
          chk($sformatf("rnd%0d.chaves", g), 32'(db_chaves), 32'(w));
          done = 1'b1;
        end else if (i == DEPTH - 1) begin
          chk_st($sformatf("rnd%0d.hit", g), 4'hA, 2'(i), 1'b1, 1'b1, 1'b0);
        end else begin
          chk($sformatf("rnd%0d.prox", g), 32'(db_estado), 32'h5);
          tick();
          chk_st($sformatf("rnd%0d.next", g), 4'h2, 2'(i + 1), 1'b0, 1'b0, 1'b0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
